// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch F, load/store D) arbiter for a single fixed-latency memory port.
// Define ARB_RR_EN for round-robin on contested grants; default is fixed priority D over F.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data_out,
    input  logic [DW-1:0] data_in,
    output logic          busy
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_d, last_d_nxt;
    logic          cur_d, cur_d_nxt;
    logic          pick_d;
    logic          d_gnt_nxt, f_gnt_nxt, d_rvalid_nxt, f_rvalid_nxt;
    logic          mem_read_nxt, mem_write_nxt;
    logic [DW-1:0] d_rdata_nxt, f_rdata_nxt, data_out_nxt;
    logic [AW-1:0] address_nxt;

`ifdef ARB_RR_EN
    // last_d resets to 0 (F was last), so the first contested grant goes to D
    assign pick_d = d_req & (~f_req | ~last_d);
`else
    assign pick_d = d_req;
`endif

    assign busy = (state == ACCESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_d    <= 1'b0;
            cur_d     <= 1'b0;
            d_gnt     <= 1'b0;
            f_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            f_rvalid  <= 1'b0;
            d_rdata   <= '0;
            f_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            address   <= '0;
            data_out  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_d    <= last_d_nxt;
            cur_d     <= cur_d_nxt;
            d_gnt     <= d_gnt_nxt;
            f_gnt     <= f_gnt_nxt;
            d_rvalid  <= d_rvalid_nxt;
            f_rvalid  <= f_rvalid_nxt;
            d_rdata   <= d_rdata_nxt;
            f_rdata   <= f_rdata_nxt;
            mem_read  <= mem_read_nxt;
            mem_write <= mem_write_nxt;
            address   <= address_nxt;
            data_out  <= data_out_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_d_nxt    = last_d;
        cur_d_nxt     = cur_d;
        d_gnt_nxt     = 1'b0;
        f_gnt_nxt     = 1'b0;
        d_rvalid_nxt  = 1'b0;
        f_rvalid_nxt  = 1'b0;
        d_rdata_nxt   = d_rdata;
        f_rdata_nxt   = f_rdata;
        mem_read_nxt  = mem_read;
        mem_write_nxt = mem_write;
        address_nxt   = address;
        data_out_nxt  = data_out;
        unique case (state)
            IDLE: begin
                if (d_req || f_req) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                    cur_d_nxt = pick_d;
                    if (pick_d) begin
                        address_nxt   = d_addr;
                        data_out_nxt  = d_wdata;
                        mem_write_nxt = d_we;
                        mem_read_nxt  = ~d_we;
                        d_gnt_nxt     = 1'b1;
                    end else begin
                        address_nxt  = f_addr;
                        mem_read_nxt = 1'b1;
                        f_gnt_nxt    = 1'b1;
                    end
                end
            end
            ACCESS: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt     = IDLE;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    last_d_nxt    = cur_d;
                    if (mem_read) begin
                        if (cur_d) begin
                            d_rdata_nxt  = data_in;
                            d_rvalid_nxt = 1'b1;
                        end else begin
                            f_rdata_nxt  = data_in;
                            f_rvalid_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle-arithmetic reference model, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_req, d_we, f_req;
    logic [15:0] d_addr, d_wdata, f_addr, data_in;
    logic        d_gnt, d_rvalid, f_gnt, f_rvalid, mem_read, mem_write, busy;
    logic [15:0] d_rdata, f_rdata, address, data_out;

    logic        d1_req, d1_we, f1_req;
    logic [15:0] d1_addr, d1_wdata, f1_addr, data_in1;
    logic        d1_gnt, d1_rvalid, f1_gnt, f1_rvalid, mem_read1, mem_write1, busy1;
    logic [15:0] d1_rdata, f1_rdata, address1, data_out1;

    int checks = 0;
    int errors = 0;
    int tcyc   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .address(address), .data_out(data_out),
        .data_in(data_in), .busy(busy)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr), .d_wdata(d1_wdata),
        .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
        .f_req(f1_req), .f_addr(f1_addr), .f_gnt(f1_gnt), .f_rvalid(f1_rvalid), .f_rdata(f1_rdata),
        .mem_read(mem_read1), .mem_write(mem_write1), .address(address1), .data_out(data_out1),
        .data_in(data_in1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an access is described only by its grant cycle m_g and winner;
    // every output is a function of how far the current cycle is from m_g.
    int          cyc = 0;
    int          m_g = -100;
    bit          m_win_d, m_we, m_last_d;
    logic [15:0] m_addr, m_wdata, m_drd, m_frd;
    bit          rr_mode;

    initial begin
`ifdef ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_g = -100; m_win_d = 0; m_we = 0; m_last_d = 0;
            m_addr = 0; m_wdata = 0; m_drd = 0; m_frd = 0;
        end else begin
            cyc++;
            if (cyc == m_g + L) begin
                if (!m_we) begin
                    if (m_win_d) m_drd = data_in;
                    else         m_frd = data_in;
                end
                m_last_d = m_win_d;
            end else if (cyc >= m_g + L + 1 && (d_req || f_req)) begin
                m_win_d = d_req && (!f_req || !rr_mode || !m_last_d);
                m_g = cyc;
                if (m_win_d) begin
                    m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                end else begin
                    m_we = 0; m_addr = f_addr;
                end
            end
        end
    end

    bit e_acc;
    always @(negedge clk) begin
        e_acc = (cyc >= m_g) && (cyc < m_g + L);
        chk("busy", busy, e_acc);
        chk("d_gnt", d_gnt, (cyc == m_g) && m_win_d);
        chk("f_gnt", f_gnt, (cyc == m_g) && !m_win_d);
        chk("mem_read", mem_read, e_acc && !m_we);
        chk("mem_write", mem_write, e_acc && m_we);
        chk("address", address, m_addr);
        chk("data_out", data_out, m_wdata);
        chk("d_rvalid", d_rvalid, (cyc == m_g + L) && !m_we && m_win_d);
        chk("f_rvalid", f_rvalid, (cyc == m_g + L) && !m_we && !m_win_d);
        chk("d_rdata", d_rdata, m_drd);
        chk("f_rdata", f_rdata, m_frd);
    end

    task automatic step();
        @(negedge clk);
        #1;
        tcyc++;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    bit gw[6];
    int n, cnt, c0;

    initial begin
        reset = 1'b1;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; f_req = 0; f_addr = 0; data_in = 0;
        d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0; f1_req = 0; f1_addr = 0; data_in1 = 0;
        step(); step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_address", address, 0);
        reset = 1'b0;

        // single fetch read
        f_req = 1; f_addr = 16'h0010; data_in = 16'hBEEF;
        step();
        chk("t1_f_gnt", f_gnt, 1);
        chk("t1_mem_read_c1", mem_read, 1);
        chk("t1_address", address, 16'h0010);
        chk("t1_busy_c1", busy, 1);
        f_req = 0;
        step();
        chk("t1_mem_read_c2", mem_read, 1);
        step();
        chk("t1_f_rvalid", f_rvalid, 1);
        chk("t1_f_rdata", f_rdata, 16'hBEEF);
        chk("t1_mem_read_c3", mem_read, 0);
        chk("t1_busy_c3", busy, 0);

        // data store
        d_req = 1; d_we = 1; d_addr = 16'h0100; d_wdata = 16'h1234;
        step();
        chk("t2_d_gnt", d_gnt, 1);
        chk("t2_mem_write_c1", mem_write, 1);
        chk("t2_address", address, 16'h0100);
        chk("t2_data_out", data_out, 16'h1234);
        d_req = 0; d_we = 0;
        step();
        chk("t2_mem_write_c2", mem_write, 1);
        step();
        chk("t2_mem_write_c3", mem_write, 0);
        chk("t2_d_rvalid", d_rvalid, 0);

        // both requesters held continuously
        pulse_reset();
        d_req = 1; d_we = 0; d_addr = 16'h0200; f_req = 1; f_addr = 16'h0300;
        n = 0; cnt = 0;
        while (n < 6 && cnt < 60) begin
            step();
            cnt++;
            if (d_gnt) begin gw[n] = 1; n++; end
            else if (f_gnt) begin gw[n] = 0; n++; end
        end
        chk("t3_grant_count", n, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_winner%0d", i), gw[i], rr_mode ? ((i % 2) == 0) : 1'b1);

        // held fetch: one grant every MEM_LAT+1 cycles
        d_req = 0; data_in = 16'hBEEF;
        cnt = 0;
        while (!f_gnt && cnt < 20) begin step(); cnt++; end
        chk("t4_first_gnt", f_gnt, 1);
        c0 = tcyc;
        step();
        cnt = 0;
        while (!f_gnt && cnt < 20) begin step(); cnt++; end
        chk("t4_gap", tcyc - c0, L + 1);
        chk("t4_rdata_hold", f_rdata, 16'hBEEF);

        // reset in the second access cycle of a read
        f_req = 0;
        cnt = 0;
        while (busy && cnt < 20) begin step(); cnt++; end
        step();
        f_req = 1; f_addr = 16'h0040; data_in = 16'hBEEF;
        step();
        chk("t5_f_gnt", f_gnt, 1);
        step();
        chk("t5_mem_read_c2", mem_read, 1);
        reset = 1'b1;
        #1;
        chk("t5_mem_read_drop", mem_read, 0);
        chk("t5_busy_drop", busy, 0);
        step();
        chk("t5_no_rvalid", f_rvalid, 0);
        reset = 1'b0;
        cnt = 0;
        while (!f_gnt && cnt < 20) begin step(); cnt++; end
        chk("t5_regrant", f_gnt, 1);
        f_req = 0;
        step(); step();
        chk("t5_f_rvalid", f_rvalid, 1);
        chk("t5_f_rdata", f_rdata, 16'hBEEF);

        // single-cycle latency instance
        d1_req = 1; d1_we = 0; d1_addr = 16'h0002; data_in1 = 16'h00AA;
        step();
        chk("t6_d_gnt", d1_gnt, 1);
        chk("t6_mem_read_c1", mem_read1, 1);
        chk("t6_address", address1, 16'h0002);
        d1_req = 0;
        step();
        chk("t6_mem_read_c2", mem_read1, 0);
        chk("t6_d_rvalid", d1_rvalid, 1);
        chk("t6_d_rdata", d1_rdata, 16'h00AA);
        step();
        chk("t6_d_rvalid_pulse", d1_rvalid, 0);

        // randomized traffic; requests held until granted, occasionally withdrawn
        for (int k = 0; k < 3000; k++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 499) == 0) reset = 1'b1;
            data_in = 16'($urandom);
            if (d_gnt) d_req = 0;
            else if (d_req && $urandom_range(0, 19) == 0) d_req = 0;
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            if (f_gnt) f_req = 0;
            else if (f_req && $urandom_range(0, 19) == 0) f_req = 0;
            if (!f_req && $urandom_range(0, 2) == 0) begin
                f_req = 1; f_addr = 16'($urandom);
            end
            step();
        end
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
